// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit MIPS-style ALU with HI/LO next-state logic
module alu (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALU_control,
    input  logic [4:0]  shiftAmount,
    input  logic [31:0] HI_IN,
    input  logic [31:0] LO_IN,
    output logic [31:0] aluResult,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
);

    localparam logic [5:0] OP_SLL   = 6'b000000;
    localparam logic [5:0] OP_SRL   = 6'b000010;
    localparam logic [5:0] OP_SRA   = 6'b000011;
    localparam logic [5:0] OP_SLLV  = 6'b000100;
    localparam logic [5:0] OP_SRLV  = 6'b000110;
    localparam logic [5:0] OP_SRAV  = 6'b000111;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_MFHI  = 6'b010000;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MFLO  = 6'b010010;
    localparam logic [5:0] OP_MTLO  = 6'b010011;
    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_ADDU  = 6'b100001;
    localparam logic [5:0] OP_SUB   = 6'b100010;
    localparam logic [5:0] OP_SUBU  = 6'b100011;
    localparam logic [5:0] OP_AND   = 6'b100100;
    localparam logic [5:0] OP_OR    = 6'b100101;
    localparam logic [5:0] OP_XOR   = 6'b100110;
    localparam logic [5:0] OP_NOR   = 6'b100111;
    localparam logic [5:0] OP_SLT   = 6'b101010;
    localparam logic [5:0] OP_SLTU  = 6'b101011;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    logic [31:0] res_c;
    logic [31:0] hi_c;
    logic [31:0] lo_c;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        div_overflow;
    logic        clk_tie;

    // CLK has no datapath role; it feeds a constant-zero term so the port is referenced
    assign clk_tie = CLK & ~CLK;

    // Full-width products; sign extension selects signed vs unsigned interpretation
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'h0, A} * {32'h0, B};

    // Divisor forced nonzero so the divider never sees zero; the B=0 case is handled by pass-through
    assign divisor      = (B == 32'h0) ? 32'h1 : B;
    // INT_MIN / -1 overflows the signed quotient; it is resolved explicitly below
    assign div_overflow = (A == INT_MIN) && (B == NEG_ONE);

    // Signed divide truncates toward zero; remainder carries the dividend's sign
    always_comb begin
        quot_s = 32'h0;
        rem_s  = 32'h0;
        if (div_overflow) begin
            quot_s = INT_MIN;
            rem_s  = 32'h0;
        end else begin
            quot_s = $signed(A) / $signed(divisor);
            rem_s  = $signed(A) % $signed(divisor);
        end
    end

    assign quot_u = A / divisor;
    assign rem_u  = A % divisor;

    // Operation decode: stage result plus next HI/LO values
    always_comb begin
        res_c = 32'h0;
        hi_c  = HI_IN;
        lo_c  = LO_IN;
        case (ALU_control)
            OP_ADD, OP_ADDU: res_c = A + B;
            OP_SUB, OP_SUBU: res_c = A - B;
            OP_AND:          res_c = A & B;
            OP_OR:           res_c = A | B;
            OP_XOR:          res_c = A ^ B;
            OP_NOR:          res_c = ~(A | B);
            OP_SLT:          res_c = {31'h0, ($signed(A) < $signed(B))};
            OP_SLTU:         res_c = {31'h0, (A < B)};
            OP_SLL:          res_c = B << shiftAmount;
            OP_SRL:          res_c = B >> shiftAmount;
            OP_SRA:          res_c = $signed(B) >>> shiftAmount;
            OP_SLLV:         res_c = B << A[4:0];
            OP_SRLV:         res_c = B >> A[4:0];
            OP_SRAV:         res_c = $signed(B) >>> A[4:0];
            OP_LUI:          res_c = {B[15:0], 16'h0};
            OP_MFHI:         res_c = HI_IN;
            OP_MFLO:         res_c = LO_IN;
            OP_MTHI:         hi_c  = A;
            OP_MTLO:         lo_c  = A;
            OP_MULT: begin
                hi_c = prod_s[63:32];
                lo_c = prod_s[31:0];
            end
            OP_MULTU: begin
                hi_c = prod_u[63:32];
                lo_c = prod_u[31:0];
            end
            OP_DIV: begin
                if (B != 32'h0) begin
                    hi_c = rem_s;
                    lo_c = quot_s;
                end
            end
            OP_DIVU: begin
                if (B != 32'h0) begin
                    hi_c = rem_u;
                    lo_c = quot_u;
                end
            end
            default: res_c = 32'h0;
        endcase
    end

    // Asynchronous active-low reset gates every output to zero; no state is held
    always_comb begin
        aluResult = 32'h0;
        HI_OUT    = 32'h0;
        LO_OUT    = 32'h0;
        if (RESET) begin
            aluResult = res_c | {32{clk_tie}};
            HI_OUT    = hi_c;
            LO_OUT    = lo_c;
        end
    end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu
module tb_alu;

    logic        CLK;
    logic        RESET;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  ALU_control;
    logic [4:0]  shiftAmount;
    logic [31:0] HI_IN;
    logic [31:0] LO_IN;
    logic [31:0] aluResult;
    logic [31:0] HI_OUT;
    logic [31:0] LO_OUT;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];

    alu dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .A          (A),
        .B          (B),
        .ALU_control(ALU_control),
        .shiftAmount(shiftAmount),
        .HI_IN      (HI_IN),
        .LO_IN      (LO_IN),
        .aluResult  (aluResult),
        .HI_OUT     (HI_OUT),
        .LO_OUT     (LO_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (aluResult === e.res) else begin
            errors++;
            $error("FAIL %s.result observed=%h expected=%h", e.tag, aluResult, e.res);
        end
        checks++;
        assert (HI_OUT === e.hi) else begin
            errors++;
            $error("FAIL %s.hi observed=%h expected=%h", e.tag, HI_OUT, e.hi);
        end
        checks++;
        assert (LO_OUT === e.lo) else begin
            errors++;
            $error("FAIL %s.lo observed=%h expected=%h", e.tag, LO_OUT, e.lo);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] hi_in, input logic [31:0] lo_in,
                        input logic [31:0] er, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        @(negedge CLK);
        ALU_control = ctrl;
        A           = a;
        B           = b;
        shiftAmount = sh;
        HI_IN       = hi_in;
        LO_IN       = lo_in;
        e.tag = tag; e.res = er; e.hi = eh; e.lo = el;
        sb.push_back(e);
        #2;
        check_out();
    endtask

    initial begin
        exp_t e;
        RESET       = 1'b1;
        A           = 32'h0;
        B           = 32'h0;
        ALU_control = 6'b100000;
        shiftAmount = 5'd0;
        HI_IN       = 32'h0;
        LO_IN       = 32'h0;

        // Reset asserted mid-cycle, away from any clock edge
        #3;
        RESET = 1'b0;
        A = 32'd5; B = 32'd7; HI_IN = 32'h11; LO_IN = 32'h22;
        #1;
        e.tag = "reset_low"; e.res = 32'h0; e.hi = 32'h0; e.lo = 32'h0;
        sb.push_back(e);
        check_out();
        // Release: outputs follow without a clock edge
        RESET = 1'b1;
        #1;
        e.tag = "reset_release"; e.res = 32'd12; e.hi = 32'h11; e.lo = 32'h22;
        sb.push_back(e);
        check_out();

        // Arithmetic / logic
        step("add_wrap", 6'b100000, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h11, 32'h22, 32'h80000000, 32'h11, 32'h22);
        step("addu",     6'b100001, 32'hFFFFFFFF, 32'h2, 5'd0, 32'h11, 32'h22, 32'h00000001, 32'h11, 32'h22);
        step("sub",      6'b100010, 32'd3, 32'd5, 5'd0, 32'h11, 32'h22, 32'hFFFFFFFE, 32'h11, 32'h22);
        step("subu",     6'b100011, 32'd10, 32'd4, 5'd0, 32'h11, 32'h22, 32'h00000006, 32'h11, 32'h22);
        step("and",      6'b100100, 32'hF0F0, 32'hFF00, 5'd0, 32'h11, 32'h22, 32'h0000F000, 32'h11, 32'h22);
        step("or",       6'b100101, 32'hF0F0, 32'hFF00, 5'd0, 32'h11, 32'h22, 32'h0000FFF0, 32'h11, 32'h22);
        step("xor",      6'b100110, 32'hF0F0, 32'hFF00, 5'd0, 32'h11, 32'h22, 32'h00000FF0, 32'h11, 32'h22);
        step("nor",      6'b100111, 32'h0, 32'h0, 5'd0, 32'h11, 32'h22, 32'hFFFFFFFF, 32'h11, 32'h22);
        step("slt",      6'b101010, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h11, 32'h22, 32'h1, 32'h11, 32'h22);
        step("sltu",     6'b101011, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h11, 32'h22, 32'h0, 32'h11, 32'h22);

        // Shifts
        step("sll4",     6'b000000, 32'h0, 32'h80000010, 5'd4,  32'h11, 32'h22, 32'h00000100, 32'h11, 32'h22);
        step("srl4",     6'b000010, 32'h0, 32'h80000010, 5'd4,  32'h11, 32'h22, 32'h08000001, 32'h11, 32'h22);
        step("sra4",     6'b000011, 32'h0, 32'h80000010, 5'd4,  32'h11, 32'h22, 32'hF8000001, 32'h11, 32'h22);
        step("sll0",     6'b000000, 32'h0, 32'h80000010, 5'd0,  32'h11, 32'h22, 32'h80000010, 32'h11, 32'h22);
        step("sra31",    6'b000011, 32'h0, 32'h80000010, 5'd31, 32'h11, 32'h22, 32'hFFFFFFFF, 32'h11, 32'h22);
        step("srl31",    6'b000010, 32'h0, 32'h80000010, 5'd31, 32'h11, 32'h22, 32'h00000001, 32'h11, 32'h22);
        step("sllv",     6'b000100, 32'h24, 32'h80000010, 5'd9, 32'h11, 32'h22, 32'h00000100, 32'h11, 32'h22);
        step("srlv",     6'b000110, 32'h24, 32'h80000010, 5'd9, 32'h11, 32'h22, 32'h08000001, 32'h11, 32'h22);
        step("srav",     6'b000111, 32'h24, 32'h80000010, 5'd9, 32'h11, 32'h22, 32'hF8000001, 32'h11, 32'h22);
        step("lui",      6'b001111, 32'h0, 32'hABCD1234, 5'd0,  32'h11, 32'h22, 32'h12340000, 32'h11, 32'h22);

        // Multiply
        step("mult",     6'b011000, 32'hFFFFFFFE, 32'd3, 5'd0, 32'h11, 32'h22, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        step("multu",    6'b011001, 32'hFFFFFFFE, 32'd3, 5'd0, 32'h11, 32'h22, 32'h0, 32'h00000002, 32'hFFFFFFFA);

        // Divide
        step("div_neg",  6'b011010, 32'hFFFFFFF9, 32'd2, 5'd0, 32'h11, 32'h22, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        step("div_negb", 6'b011010, 32'd7, 32'hFFFFFFFE, 5'd0, 32'h11, 32'h22, 32'h0, 32'h00000001, 32'hFFFFFFFD);
        step("divu",     6'b011011, 32'd7, 32'd2, 5'd0, 32'h11, 32'h22, 32'h0, 32'h00000001, 32'h00000003);
        step("div_zero", 6'b011010, 32'd7, 32'd0, 5'd0, 32'hAA, 32'hBB, 32'h0, 32'hAA, 32'hBB);
        step("divu_zero",6'b011011, 32'd7, 32'd0, 5'd0, 32'hAA, 32'hBB, 32'h0, 32'hAA, 32'hBB);
        step("div_ovf",  6'b011010, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h11, 32'h22, 32'h0, 32'h0, 32'h80000000);

        // HI/LO moves and pass-through
        step("mthi",     6'b010001, 32'h55, 32'h0, 5'd0, 32'h66, 32'h77, 32'h0, 32'h55, 32'h77);
        step("mtlo",     6'b010011, 32'h44, 32'h0, 5'd0, 32'h66, 32'h77, 32'h0, 32'h66, 32'h44);
        step("mfhi",     6'b010000, 32'h1, 32'h2, 5'd0, 32'h88, 32'h99, 32'h88, 32'h88, 32'h99);
        step("mflo",     6'b010010, 32'h1, 32'h2, 5'd0, 32'h88, 32'h99, 32'h99, 32'h88, 32'h99);
        step("add_pass", 6'b100000, 32'h1, 32'h2, 5'd0, 32'h33, 32'h44, 32'h3, 32'h33, 32'h44);
        step("undef",    6'b111111, 32'h1, 32'h2, 5'd0, 32'h33, 32'h44, 32'h0, 32'h33, 32'h44);

        // Reset during a multiply forces zeros asynchronously
        @(negedge CLK);
        ALU_control = 6'b011000; A = 32'hFFFFFFFE; B = 32'd3;
        #2;
        RESET = 1'b0;
        #1;
        e.tag = "reset_mult"; e.res = 32'h0; e.hi = 32'h0; e.lo = 32'h0;
        sb.push_back(e);
        check_out();
        RESET = 1'b1;
        #1;
        e.tag = "release_mult"; e.res = 32'h0; e.hi = 32'hFFFFFFFF; e.lo = 32'hFFFFFFFA;
        sb.push_back(e);
        check_out();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Purely combinational 32-bit MIPS-style integer ALU, instantiated inside the EXE pipeline stage.
- Computes the stage result from forwarded operands A/B under a 6-bit control code.
- Computes next-state HI/LO values for multiply/divide/move-to-HI/LO. The HI/LO registers live in EXE, which feeds them back via HI_IN/LO_IN and latches HI_OUT/LO_OUT.
- Clock and reset exist for interface uniformity. The datapath holds no state.

Parameters:
- None (width fixed at 32).

Ports:
- CLK  input  1  Clock. EXE connects the inverted stage clock. No datapath function.
- RESET  input  1  Asynchronous, active-low reset.
- A  input  32  Operand A (rs value, forwarded).
- B  input  32  Operand B (rt value or extended immediate, forwarded).
- ALU_control  input  6  Operation select.
- shiftAmount  input  5  Shift amount for constant shifts.
- HI_IN  input  32  Current HI register.
- LO_IN  input  32  Current LO register.
- aluResult  output  32  Result to the MEM stage.
- HI_OUT  output  32  Next HI value.
- LO_OUT  output  32  Next LO value.

Behaviour:
- Reset:
  - While RESET=0, asynchronously: aluResult=0, HI_OUT=0, LO_OUT=0.
  - After RESET returns to 1, outputs follow inputs immediately.
- Normal operation: all outputs are combinational functions of inputs. Zero latency; no registers on the result path.
- Default HI/LO behaviour: HI_OUT=HI_IN and LO_OUT=LO_IN for every code except MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Encoding (ALU_control -> operation):
  - 100000 ADD, 100001 ADDU: A+B, modulo 2^32. No overflow trap.
  - 100010 SUB, 100011 SUBU: A-B, modulo 2^32.
  - 100100 AND; 100101 OR; 100110 XOR; 100111 NOR = ~(A|B).
  - 101010 SLT: 1 if signed A < signed B, else 0.
  - 101011 SLTU: 1 if unsigned A < unsigned B, else 0.
  - 000000 SLL: B << shiftAmount.
  - 000010 SRL: B >> shiftAmount, logical.
  - 000011 SRA: B >>> shiftAmount, sign-filling.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: as SLL/SRL/SRA, but the shift count is A[4:0]. A[31:5] is ignored.
  - 001111 LUI: {B[15:0],16'h0}.
  - 010000 MFHI: aluResult=HI_IN.
  - 010010 MFLO: aluResult=LO_IN.
  - 010001 MTHI: HI_OUT=A, aluResult=0.
  - 010011 MTLO: LO_OUT=A, aluResult=0.
  - 011000 MULT: signed 64-bit A*B; {HI_OUT,LO_OUT}=product; aluResult=0.
  - 011001 MULTU: unsigned 64-bit product; same output mapping as MULT.
  - 011010 DIV: signed; LO_OUT=quotient, truncated toward zero; HI_OUT=remainder, with the sign of the dividend; aluResult=0.
  - 011011 DIVU: unsigned; same output mapping as DIV.
  - Any other code: aluResult=0; HI/LO pass through.
- Boundary conditions:
  - Shift amount 0 returns B unchanged. Shift amount 31 is the maximum.
  - DIV/DIVU with B=0: HI_OUT=HI_IN and LO_OUT=LO_IN (no change); aluResult=0.
  - DIV 0x80000000 / 0xFFFFFFFF: LO_OUT=0x80000000, HI_OUT=0 (no exception).
  - ADD 0x7FFFFFFF+1 yields 0x80000000 (wraps silently).
- The EXE stage performs loads/stores with the ADD code; no separate address mode exists.

Test Plan:
- Reset check: RESET=0 with ALU_control=100000, A=5, B=7 -> aluResult=0, HI_OUT=0, LO_OUT=0. Release RESET -> aluResult=12 with no clock edge needed.
- Arithmetic/logic sweep:
  - ADD 0x7FFFFFFF+1 -> 0x80000000.
  - SUB 3-5 -> 0xFFFFFFFE.
  - NOR 0,0 -> 0xFFFFFFFF.
  - SLT A=0xFFFFFFFF, B=1 -> 1.
  - SLTU with the same operands -> 0.
- Shifts, B=0x80000010:
  - SLL shamt 4 -> 0x00000100.
  - SRL shamt 4 -> 0x08000001.
  - SRA shamt 4 -> 0xF8000001.
  - SRAV with A=0x24 (count 4) -> 0xF8000001.
  - LUI with B=0x1234 -> 0x12340000.
- Multiply:
  - MULT A=0xFFFFFFFE (-2), B=3 -> HI_OUT=0xFFFFFFFF, LO_OUT=0xFFFFFFFA.
  - MULTU with the same operands -> HI_OUT=2, LO_OUT=0xFFFFFFFA.
- Divide:
  - DIV A=-7, B=2 -> LO_OUT=0xFFFFFFFD, HI_OUT=0xFFFFFFFF.
  - DIVU 7/2 -> LO_OUT=3, HI_OUT=1.
  - DIV by 0 with HI_IN=0xAA, LO_IN=0xBB -> outputs 0xAA/0xBB.
- HI/LO moves and pass-through:
  - MTHI A=0x55 -> HI_OUT=0x55, LO_OUT=LO_IN.
  - MFLO with LO_IN=0x99 -> aluResult=0x99.
  - ADD -> HI_OUT=HI_IN, LO_OUT=LO_IN.
  - Undefined code 111111 -> aluResult=0.
